// File: rtl/key_pkg.sv
// key_pkg: shared channel state encoding and default timing constants
// for the two-key event generator.
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_HOLD_CYCLES     = 50000000;

endpackage

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one pushbutton -- synchronizer, debounce FSM and
// hold timer producing registered press/release/hold pulses.
`default_nettype none

module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [1:0]        sync;
    logic              ks;
    key_state_t        state, state_next;
    logic [DB_W-1:0]   db_cnt, db_cnt_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              level_next, press_next, rel_next, hold_next;

    assign ks = ~sync[1];

    // Synchronizer resets to the released (high) raw level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= 2'b11;
            state    <= RELEASED;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            rel      <= 1'b0;
            hold     <= 1'b0;
        end else begin
            sync     <= {sync[0], key_n};
            state    <= state_next;
            db_cnt   <= db_cnt_next;
            hold_cnt <= hold_cnt_next;
            level    <= level_next;
            press    <= press_next;
            rel      <= rel_next;
            hold     <= hold_next;
        end
    end

    always_comb begin
        state_next    = state;
        db_cnt_next   = db_cnt;
        hold_cnt_next = hold_cnt;
        level_next    = level;
        press_next    = 1'b0;
        rel_next      = 1'b0;
        hold_next     = 1'b0;
        case (state)
            RELEASED: begin
                if (ks) begin
                    state_next  = PRESS_PEND;
                    db_cnt_next = '0;
                end
            end
            PRESS_PEND: begin
                if (!ks) begin
                    state_next = RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    state_next    = PRESSED;
                    level_next    = 1'b1;
                    press_next    = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DB_ONE;
                end
            end
            PRESSED: begin
                if (!ks) begin
                    state_next  = RELEASE_PEND;
                    db_cnt_next = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    // Saturating at HOLD_LAST makes the hold pulse one-shot per press.
                    hold_cnt_next = hold_cnt + HOLD_ONE;
                    hold_next     = (hold_cnt + HOLD_ONE) == HOLD_LAST;
                end
            end
            RELEASE_PEND: begin
                if (ks) begin
                    state_next = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_next = RELEASED;
                    level_next = 1'b0;
                    rel_next   = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + DB_ONE;
                end
            end
            default: state_next = RELEASED;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/key_event_generator.sv
// key_event_generator: two independent debounced pushbutton channels plus
// a combined any-press strobe.
`default_nettype none

module key_event_generator
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] key_hold,
    output logic       any_press
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .key_n(KEY[gi]),
            .level(key_level[gi]),
            .press(key_press[gi]),
            .rel  (key_release[gi]),
            .hold (key_hold[gi])
        );
    end

    assign any_press = |key_press;

endmodule

`default_nettype wire

// File: tb/tb_key_event_generator.sv
// tb_key_event_generator: directed vectors for key_event_generator with
// DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.
`default_nettype none

module tb_key_event_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] KEY;
    logic [1:0] key_level, key_press, key_release, key_hold;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_generator #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_hold   (key_hold),
        .any_press  (any_press)
    );

    typedef struct {
        logic [1:0] key;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
        logic       any;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs, let one posedge sample them, observe on the following negedge.
    task automatic tick(input logic [1:0] k, input logic r);
        KEY   = k;
        reset = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(2'b11, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 2'b11;
        @(negedge clk);
        tick(2'b11, 1'b1);
        tick(2'b11, 1'b1);
        chk("reset_outputs", 0, {7'd0, key_level, key_press, key_release, key_hold, any_press}, 16'd0);
        idle(2);
        chk("idle_outputs", 0, {7'd0, key_level, key_press, key_release, key_hold, any_press}, 16'd0);

        // Clean press then release of KEY[0].
        for (int i = 0; i < 20; i++) begin
            vecs[i].key   = (i < 10) ? 2'b10 : 2'b11;
            vecs[i].level = (i >= 6 && i < 16) ? 2'b01 : 2'b00;
            vecs[i].press = (i == 6) ? 2'b01 : 2'b00;
            vecs[i].rel   = (i == 16) ? 2'b01 : 2'b00;
            vecs[i].any   = (i == 6);
        end
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].key, 1'b0);
            chk("clean_level",   i, {14'd0, key_level},   {14'd0, vecs[i].level});
            chk("clean_press",   i, {14'd0, key_press},   {14'd0, vecs[i].press});
            chk("clean_release", i, {14'd0, key_release}, {14'd0, vecs[i].rel});
            chk("clean_any",     i, {15'd0, any_press},   {15'd0, vecs[i].any});
            chk("clean_hold",    i, {14'd0, key_hold},    16'd0);
        end
        idle(4);

        // Bounce: low 3, high 1, low steady from cycle 4 -> press at cycle 10.
        for (int i = 0; i < 16; i++) begin
            tick((i == 3) ? 2'b11 : 2'b10, 1'b0);
            chk("bounce_press", i, {14'd0, key_press}, (i == 10) ? 16'd1 : 16'd0);
            chk("bounce_level", i, {14'd0, key_level}, (i >= 10) ? 16'd1 : 16'd0);
        end
        idle(12);

        // Hold KEY[1]: press at 6, hold at 15, release driven at 27 -> pulse at 33.
        for (int i = 0; i < 37; i++) begin
            tick((i < 27) ? 2'b01 : 2'b11, 1'b0);
            chk("hold_press",   i, {14'd0, key_press},   (i == 6)  ? 16'd2 : 16'd0);
            chk("hold_hold",    i, {14'd0, key_hold},    (i == 15) ? 16'd2 : 16'd0);
            chk("hold_release", i, {14'd0, key_release}, (i == 33) ? 16'd2 : 16'd0);
            chk("hold_level",   i, {14'd0, key_level},   (i >= 6 && i < 33) ? 16'd2 : 16'd0);
        end
        idle(4);

        // Two-cycle release glitch after the hold pulse: no release, no second hold.
        for (int i = 0; i < 40; i++) begin
            tick((i == 20 || i == 21) ? 2'b11 : 2'b01, 1'b0);
            chk("glitch_press",   i, {14'd0, key_press},   (i == 6)  ? 16'd2 : 16'd0);
            chk("glitch_hold",    i, {14'd0, key_hold},    (i == 15) ? 16'd2 : 16'd0);
            chk("glitch_release", i, {14'd0, key_release}, 16'd0);
            chk("glitch_level",   i, {14'd0, key_level},   (i >= 6) ? 16'd2 : 16'd0);
        end
        idle(12);

        // Both keys pressed together.
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b0);
            chk("simul_press", i, {14'd0, key_press}, (i == 6) ? 16'd3 : 16'd0);
            chk("simul_any",   i, {15'd0, any_press}, (i == 6) ? 16'd1 : 16'd0);
        end
        idle(12);

        // KEY[1] held and pressed; KEY[0] mid-debounce when reset hits, KEY[1] mid-hold.
        for (int i = 0; i < 10; i++) begin
            tick(2'b01, 1'b0);
            chk("pre_press", i, {14'd0, key_press}, (i == 6) ? 16'd2 : 16'd0);
        end
        for (int i = 0; i < 20; i++) begin
            tick(2'b00, (i == 5 || i == 6));
            if (i == 5 || i == 6)
                chk("rst_outputs", i, {7'd0, key_level, key_press, key_release, key_hold, any_press}, 16'd0);
            chk("rst_press", i, {14'd0, key_press}, (i == 13) ? 16'd3 : 16'd0);
            chk("rst_level", i, {14'd0, key_level}, (i < 5) ? 16'd2 : ((i < 13) ? 16'd0 : 16'd3));
            chk("rst_hold",  i, {14'd0, key_hold},  16'd0);
            chk("rst_any",   i, {15'd0, any_press}, (i == 13) ? 16'd1 : 16'd0);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
